// File: rtl/decode_pipe.sv
// decode_pipe: registered RV32I/RV32E decode stage between fetch and execute.
// Decodes the instruction word into control, a sign-extended immediate and
// two register-file operands, then registers everything under valid/ready.
// Ports:
//   clk_i, n_rst                  clock, synchronous active-low reset
//   valid_i/ready_o               fetch-side handshake (ready_o is combinational)
//   instruction_i, pc_i           incoming instruction and its address
//   flush_i                       kill in-flight and incoming instruction
//   ex_memread_i, ex_rd_i         load in execute, for load-use stall
//   wb_we_i, wb_rd_i, wb_data_i   register-file write port from writeback
//   valid_o/ready_i               execute-side handshake
//   pc_o, rd_o, rs1/rs2_data_o,
//   immediate_o                   registered datapath outputs
//   ex_func_o, rs1_sel_o, rs2_sel_o, memwrite_en_o, memread_en_o, wb_en_o,
//   wb_src_o, wb_pc_src_o, illegal_o  registered control outputs

package decode_pipe_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
    } ex_func;
    typedef enum logic [1:0] {RS1_REG, RS1_PC, RS1_ZERO} rs1_sel;
    typedef enum logic {RS2_REG, RS2_IMM} rs2_sel;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_source_type;
    typedef enum logic [1:0] {PC_NEXT, PC_BRANCH, PC_JAL, PC_JALR} wb_pc_source_type;
    typedef enum logic [6:0] {
        OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
        OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
        OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011,
        OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011
    } opcode_t;
    typedef struct packed {
        ex_func           func;
        rs1_sel           s1;
        rs2_sel           s2;
        logic             mw;
        logic             mr;
        logic             we;
        wb_source_type    wbs;
        wb_pc_source_type pcs;
        logic             ill;
    } ctrl_t;

    function automatic ex_func alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic ex_func br_op(input logic [2:0] f3);
        case (f3)
            3'd1:    return BR_NE;
            3'd4:    return BR_LT;
            3'd5:    return BR_GE;
            3'd6:    return BR_LTU;
            3'd7:    return BR_GEU;
            default: return BR_EQ;
        endcase
    endfunction
endpackage

module decode_pipe
    import decode_pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int BYPASS_EN = 1
) (
    input  logic             clk_i,
    input  logic             n_rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      instruction_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic             flush_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             wb_we_i,
    input  logic [4:0]       wb_rd_i,
    input  logic [XLEN-1:0]  wb_data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [4:0]       rd_o,
    output logic [XLEN-1:0]  rs1_data_o,
    output logic [XLEN-1:0]  rs2_data_o,
    output logic [XLEN-1:0]  immediate_o,
    output ex_func           ex_func_o,
    output rs1_sel           rs1_sel_o,
    output rs2_sel           rs2_sel_o,
    output logic             memwrite_en_o,
    output logic             memread_en_o,
    output logic             wb_en_o,
    output wb_source_type    wb_src_o,
    output wb_pc_source_type wb_pc_src_o,
    output logic             illegal_o
);
    localparam int         AW      = $clog2(NREGS);
    localparam logic [5:0] NREGS_W = 6'(NREGS);

    logic [4:0] rs1_f, rs2_f, rd_f;
    logic [2:0] f3;
    assign rs1_f = instruction_i[19:15];
    assign rs2_f = instruction_i[24:20];
    assign rd_f  = instruction_i[11:7];
    assign f3    = instruction_i[14:12];

    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
    assign imm_i = {{20{instruction_i[31]}}, instruction_i[31:20]};
    assign imm_s = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
    assign imm_b = {{20{instruction_i[31]}}, instruction_i[7], instruction_i[30:25],
                    instruction_i[11:8], 1'b0};
    assign imm_u = {instruction_i[31:12], 12'b0};
    assign imm_j = {{12{instruction_i[31]}}, instruction_i[19:12], instruction_i[20],
                    instruction_i[30:21], 1'b0};

    ctrl_t dec;
    logic  legal, use_rs1, use_rs2, use_rd;

    always_comb begin
        dec     = '0;
        imm32   = '0;
        legal   = 1'b1;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        case (opcode_t'(instruction_i[6:0]))
            OP_LUI:    begin use_rd = 1'b1; dec.s1 = RS1_ZERO; dec.s2 = RS2_IMM; dec.we = 1'b1; imm32 = imm_u; end
            OP_AUIPC:  begin use_rd = 1'b1; dec.s1 = RS1_PC; dec.s2 = RS2_IMM; dec.we = 1'b1; imm32 = imm_u; end
            OP_JAL: begin
                use_rd = 1'b1; dec.s1 = RS1_PC; dec.s2 = RS2_IMM; dec.we = 1'b1;
                dec.wbs = WB_PC4; dec.pcs = PC_JAL; imm32 = imm_j;
            end
            OP_JALR: begin
                use_rs1 = 1'b1; use_rd = 1'b1; dec.s2 = RS2_IMM; dec.we = 1'b1;
                dec.wbs = WB_PC4; dec.pcs = PC_JALR; imm32 = imm_i;
            end
            OP_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; dec.func = br_op(f3);
                dec.pcs = PC_BRANCH; imm32 = imm_b;
            end
            OP_LOAD: begin
                use_rs1 = 1'b1; use_rd = 1'b1; dec.s2 = RS2_IMM; dec.mr = 1'b1;
                dec.we = 1'b1; dec.wbs = WB_MEM; imm32 = imm_i;
            end
            OP_STORE:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; dec.s2 = RS2_IMM; dec.mw = 1'b1; imm32 = imm_s; end
            OP_IMM: begin
                // Only shift-right immediates use bit 30 as a function select.
                use_rs1 = 1'b1; use_rd = 1'b1; dec.s2 = RS2_IMM; dec.we = 1'b1;
                dec.func = alu_op(f3, (f3 == 3'b101) & instruction_i[30]); imm32 = imm_i;
            end
            OP_REG: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; dec.we = 1'b1;
                dec.func = alu_op(f3, instruction_i[30]);
            end
            OP_FENCE, OP_SYSTEM: begin end
            default:   legal = 1'b0;
        endcase
        dec.ill = ~legal
                | (use_rs1 & ({1'b0, rs1_f} >= NREGS_W))
                | (use_rs2 & ({1'b0, rs2_f} >= NREGS_W))
                | (use_rd  & ({1'b0, rd_f}  >= NREGS_W));
        if (dec.ill) begin
            dec.mw = 1'b0;
            dec.mr = 1'b0;
            dec.we = 1'b0;
        end
    end

    // Register file; entry 0 exists but is never written or read.
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] rs1_rd, rs2_rd;

    always_ff @(posedge clk_i) begin
        if (!n_rst) begin
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wb_we_i && (wb_rd_i != '0) && ({1'b0, wb_rd_i} < NREGS_W)) begin
            regs_q[wb_rd_i[AW-1:0]] <= wb_data_i;
        end
    end

    always_comb begin
        rs1_rd = '0;
        rs2_rd = '0;
        if ((rs1_f != '0) && ({1'b0, rs1_f} < NREGS_W)) rs1_rd = regs_q[rs1_f[AW-1:0]];
        if ((rs2_f != '0) && ({1'b0, rs2_f} < NREGS_W)) rs2_rd = regs_q[rs2_f[AW-1:0]];
        if ((BYPASS_EN != 0) && wb_we_i && (wb_rd_i == rs1_f) && (rs1_f != '0)) rs1_rd = wb_data_i;
        if ((BYPASS_EN != 0) && wb_we_i && (wb_rd_i == rs2_f) && (rs2_f != '0)) rs2_rd = wb_data_i;
    end

    logic hazard, can_adv;
    assign hazard  = valid_i & ex_memread_i & (ex_rd_i != '0)
                   & ((ex_rd_i == rs1_f) | (ex_rd_i == rs2_f));
    assign can_adv = ~valid_o | ready_i;
    assign ready_o = flush_i | (~hazard & can_adv);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d, op1_q, op1_d, op2_q, op2_d, imm_q, imm_d;
    logic [4:0]      rd_q, rd_d;
    ctrl_t           ctrl_q, ctrl_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        rd_d    = rd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        imm_d   = imm_q;
        ctrl_d  = ctrl_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (hazard && can_adv) begin
            valid_d = 1'b0;
        end else if (valid_i && ready_o) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            rd_d    = use_rd ? rd_f : '0;
            op1_d   = rs1_rd;
            op2_d   = rs2_rd;
            imm_d   = XLEN'(imm32);
            ctrl_d  = dec;
        end else if (valid_q && !ready_i) begin
            // stall: everything holds
        end else begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!n_rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rd_q    <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            imm_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid_o       = valid_q;
    assign pc_o          = pc_q;
    assign rd_o          = rd_q;
    assign rs1_data_o    = op1_q;
    assign rs2_data_o    = op2_q;
    assign immediate_o   = imm_q;
    assign ex_func_o     = ctrl_q.func;
    assign rs1_sel_o     = ctrl_q.s1;
    assign rs2_sel_o     = ctrl_q.s2;
    assign memwrite_en_o = ctrl_q.mw;
    assign memread_en_o  = ctrl_q.mr;
    assign wb_en_o       = ctrl_q.we;
    assign wb_src_o      = ctrl_q.wbs;
    assign wb_pc_src_o   = ctrl_q.pcs;
    assign illegal_o     = ctrl_q.ill;
endmodule
